// File: rtl/dsp_simd_addsub.sv
// dsp_simd_addsub: two-stage pipelined SIMD add/sub/accumulate with per-lane carry and valid/ready flow control
module dsp_simd_addsub #(
  parameter int lanes    = 3,
  parameter int width    = 12,
  parameter bit saturate = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [1:0]             i_op,
  input  logic [lanes*width-1:0] i_a,
  input  logic [lanes*width-1:0] i_b,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [lanes*width-1:0] o_y,
  output logic [lanes-1:0]       o_carry
);
  localparam int lw = lanes * width;
  if (!(width >= 1 && ((lanes >= 3 && lanes <= 4 && width <= 12) ||
        (lanes == 2 && width <= 24) || (lanes == 1 && width <= 48)))) begin : g_bad_cfg
    $error("dsp_simd_addsub: unsupported lanes/width combination");
  end
  logic          r_v1, r_v2;
  logic [1:0]    r_op1;
  logic [lw-1:0] r_a1, r_b1, r_acc, r_y, w_y;
  logic [lanes-1:0] r_c, w_c;
  logic          w_adv;
  assign w_adv       = !r_v2 || i_out_ready;
  assign o_in_ready  = w_adv;
  assign o_out_valid = r_v2;
  assign o_y         = r_y;
  assign o_carry     = r_c;
  // Each lane computes at width+1 bits; the top bit is carry or borrow and never leaks into the neighbour.
  for (genvar i = 0; i < lanes; i++) begin : g_lane
    logic [width-1:0] w_a, w_b, w_acc;
    logic [width:0]   w_r;
    assign w_a   = r_a1[i*width +: width];
    assign w_b   = r_b1[i*width +: width];
    assign w_acc = r_acc[i*width +: width];
    always_comb
      w_r = (r_op1 == 2'd0) ? {1'b0, w_a} + {1'b0, w_b} :
            (r_op1 == 2'd1) ? {1'b0, w_a} - {1'b0, w_b} :
            (r_op1 == 2'd2) ? {1'b0, w_acc} + {1'b0, w_a} : {1'b0, w_a};
    assign w_c[i] = (r_op1 != 2'd3) && w_r[width];
    assign w_y[i*width +: width] = (saturate && w_c[i]) ? ((r_op1 == 2'd1) ? '0 : '1) : w_r[width-1:0];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_v1  <= 1'b0;
      r_op1 <= '0;
      r_a1  <= '0;
      r_b1  <= '0;
      r_v2  <= 1'b0;
      r_y   <= '0;
      r_c   <= '0;
      r_acc <= '0;
    end else if (w_adv) begin
      r_v1  <= i_in_valid;
      r_op1 <= i_op;
      r_a1  <= i_a;
      r_b1  <= i_b;
      r_v2  <= r_v1;
      if (r_v1) begin
        r_y <= w_y;
        r_c <= w_c;
        if (r_op1[1]) r_acc <= w_y;
      end
    end
endmodule

// File: tb/tb_dsp_simd_addsub.sv
// tb_dsp_simd_addsub: table-driven vectors plus scoreboard over three lane/width/saturate configurations
module tb_dsp_simd_addsub;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, ordy = 1'b1;
  logic [1:0] op = '0;
  logic [35:0] a0 = '0, b0 = '0;
  logic [47:0] a1, b1, a2 = '0, b2 = '0;
  logic ir0, ir1, ir2, ov0, ov1, ov2;
  logic [35:0] y0;
  logic [47:0] y1, y2;
  logic [2:0] c0;
  logic [3:0] c1;
  logic [0:0] c2;
  assign a1 = {a0[11:0], a0};
  assign b1 = {b0[11:0], b0};
  always #5 clk = ~clk;

  dsp_simd_addsub #(.lanes(3), .width(12), .saturate(1'b0)) d0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(valid), .o_in_ready(ir0), .i_op(op),
    .i_a(a0), .i_b(b0), .o_out_valid(ov0), .i_out_ready(ordy), .o_y(y0), .o_carry(c0));
  dsp_simd_addsub #(.lanes(4), .width(12), .saturate(1'b0)) d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(valid), .o_in_ready(ir1), .i_op(op),
    .i_a(a1), .i_b(b1), .o_out_valid(ov1), .i_out_ready(ordy), .o_y(y1), .o_carry(c1));
  dsp_simd_addsub #(.lanes(1), .width(48), .saturate(1'b1)) d2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(valid), .o_in_ready(ir2), .i_op(op),
    .i_a(a2), .i_b(b2), .o_out_valid(ov2), .i_out_ready(ordy), .o_y(y2), .o_carry(c2));

  typedef struct {
    logic [1:0]  op;
    logic [35:0] a, b;
    logic [47:0] za, zb;
    logic [35:0] ey;
    logic [2:0]  ec;
  } row_t;
  row_t tbl[9];
  logic [51:0] q0[$], q1[$], q2[$];
  logic [47:0] macc0 = '0, macc1 = '0, macc2 = '0;
  int n_checks = 0, n_fail = 0, cyc = 0, first_pop = -1, last_pop = -1;

  task automatic chk(input string nm, input logic [51:0] act, input logic [51:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [51:0] model(int nl, int w, bit sat, logic [1:0] o,
                                        logic [47:0] a, logic [47:0] b, logic [47:0] acc);
    logic [48:0] m, ai, bi, ci, r, yi;
    logic [47:0] y;
    logic [3:0] cy;
    bit c;
    m = (49'd1 << w) - 49'd1;
    y = '0;
    cy = '0;
    for (int i = 0; i < nl; i++) begin
      ai = ({1'b0, a} >> (i * w)) & m;
      bi = ({1'b0, b} >> (i * w)) & m;
      ci = ({1'b0, acc} >> (i * w)) & m;
      case (o)
        2'd0: r = ai + bi;
        2'd1: r = ai - bi;
        2'd2: r = ci + ai;
        default: r = ai;
      endcase
      c = (o == 2'd1) ? (ai < bi) : (o == 2'd3) ? 1'b0 : r[w];
      yi = (sat && c) ? ((o == 2'd1) ? 49'd0 : m) : (r & m);
      y = y | 48'(yi << (i * w));
      cy[i] = c;
    end
    return {cy, y};
  endfunction

  task automatic send(input logic [1:0] o, input logic [35:0] xa, input logic [35:0] xb,
                      input logic [47:0] za, input logic [47:0] zb, input bit tab,
                      input logic [35:0] ey, input logic [2:0] ec);
    logic [51:0] e;
    bit ok;
    int n;
    op = o; a0 = xa; b0 = xb; a2 = za; b2 = zb; valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk) ok = ir0;
      @(posedge clk);
      n++;
    end
    if (!ok) chk("accept timeout", 52'd0, 52'd1);
    else begin
      e = model(3, 12, 1'b0, o, {12'b0, xa}, {12'b0, xb}, macc0);
      if (o[1]) macc0 = e[47:0];
      q0.push_back(tab ? {1'b0, ec, 12'b0, ey} : e);
      e = model(4, 12, 1'b0, o, {xa[11:0], xa}, {xb[11:0], xb}, macc1);
      if (o[1]) macc1 = e[47:0];
      q1.push_back(e);
      e = model(1, 48, 1'b1, o, za, zb, macc2);
      if (o[1]) macc2 = e[47:0];
      q2.push_back(e);
    end
    #1 valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 52'(q0.size() + q1.size() + q2.size()), 52'd0);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (ov0 && !ordy) chk("in_ready stall", {51'b0, ir0}, 52'd0);
    if (ov0 && !ordy && q0.size() > 0) chk("d0 hold", {1'b0, c0, 12'b0, y0}, q0[0]);
    if (ov0 && ordy) begin
      if (q0.size() == 0) chk("d0 extra beat", 52'd1, 52'd0);
      else begin
        chk("d0 y/carry", {1'b0, c0, 12'b0, y0}, q0.pop_front());
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    if (ov1 && ordy) begin
      if (q1.size() == 0) chk("d1 extra beat", 52'd1, 52'd0);
      else chk("d1 y/carry", {c1, y1}, q1.pop_front());
    end
    if (ov2 && ordy) begin
      if (q2.size() == 0) chk("d2 extra beat", 52'd1, 52'd0);
      else chk("d2 y/carry", {3'b0, c2, y2}, q2.pop_front());
    end
  end

  initial begin
    tbl[0] = '{2'd0, 36'h001_7FF_FFF, 36'h001_001_001, 48'hFFFF_FFFF_FFFF, 48'd1, 36'h002_800_000, 3'b001};
    tbl[1] = '{2'd1, 36'h000_123_005, 36'h001_023_009, 48'd5, 48'd9, 36'hFFF_100_FFC, 3'b101};
    tbl[2] = '{2'd3, 36'h00A_00A_00A, 36'hFFF_FFF_FFF, 48'd10, 48'h123, 36'h00A_00A_00A, 3'b000};
    tbl[3] = '{2'd2, 36'h005_FFF_005, 36'h0, 48'd5, 48'd77, 36'h00F_009_00F, 3'b010};
    tbl[4] = '{2'd2, 36'h007_007_007, 36'h0, 48'd7, 48'd0, 36'h016_010_016, 3'b000};
    tbl[5] = '{2'd2, 36'h003_FF0_003, 36'h0, 48'd3, 48'd0, 36'h019_000_019, 3'b010};
    tbl[6] = '{2'd0, 36'hFFF_FFF_FFF, 36'hFFF_FFF_FFF, 48'd2, 48'd3, 36'hFFE_FFE_FFE, 3'b111};
    tbl[7] = '{2'd1, 36'hABC_000_FFF, 36'hABC_000_FFF, 48'd9, 48'd5, 36'h0, 3'b000};
    tbl[8] = '{2'd0, 36'hFFF_FFF_FFF, 36'h001_001_001, 48'd0, 48'd0, 36'h0, 3'b111};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", {51'b0, ov0}, 52'd0);
    chk("reset y/carry", {1'b0, c0, 12'b0, y0}, 52'd0);
    chk("reset in_ready", {51'b0, ir0}, 52'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 9; i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].za, tbl[i].zb, 1'b1, tbl[i].ey, tbl[i].ec);
    drain();
    chk("no bubbles", 52'(last_pop - first_pop), 52'd8);
    ordy = 1'b0;
    fork
      begin
        send(2'd0, 36'h003_002_001, 36'h010_020_030, 48'd100, 48'd23, 1'b0, '0, '0);
        send(2'd1, 36'h050_060_070, 36'h051_001_002, 48'd40, 48'd50, 1'b0, '0, '0);
        send(2'd0, 36'h800_400_200, 36'h800_400_200, 48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, '0, '0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 ordy = 1'b1;
      end
    join
    drain();
    send(2'd3, {12'd42, 12'd42, 12'd42}, '0, 48'd42, '0, 1'b0, '0, '0);
    drain();
    ordy = 1'b0;
    send(2'd2, 36'h001_001_001, '0, 48'd1, '0, 1'b0, '0, '0);
    send(2'd2, 36'h001_001_001, '0, 48'd1, '0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("mid reset out_valid", {49'b0, ov0, ov1, ov2}, 52'd0);
    chk("mid reset d0 y", {1'b0, c0, 12'b0, y0}, 52'd0);
    chk("mid reset d2 y", {3'b0, c2, y2}, 52'd0);
    chk("mid reset in_ready", {49'b0, ir0, ir1, ir2}, 52'd7);
    q0.delete(); q1.delete(); q2.delete();
    macc0 = '0; macc1 = '0; macc2 = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ordy = 1'b1;
    send(2'd2, 36'h001_001_001, '0, 48'd1, '0, 1'b1, 36'h001_001_001, 3'b000);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
